rom_secuenciador: RTL and testbench
===================================

Name: rom_secuenciador

Overview:
Sequential reader placed directly upstream of the 8-bit combinational ROM (11 words, 8-bit address, 8-bit data). When a start pulse arrives, it walks an inclusive address range and drives the ROM address. It registers each returned word and hands it downstream with a valid/ready handshake. It also keeps a running sum of the words delivered and flags ranges that are out of bounds.

Parameters:
ANCHO_DIR, 8, address width; matches ROM address port
ANCHO_DATO, 8, data width; matches ROM data port
PROFUNDIDAD, 11, number of valid ROM words (addresses 0..PROFUNDIDAD-1)
ANCHO_SUMA, 16, accumulator width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
inicio  input  1  start request, sampled only in IDLE
dir_inicio  input  ANCHO_DIR  first address of range, sampled with inicio
dir_fin  input  ANCHO_DIR  last address of range (inclusive), sampled with inicio
direccion  output  ANCHO_DIR  registered address to ROM
dato_rom  input  ANCHO_DATO  ROM read data (combinational from direccion)
dato_o  output  ANCHO_DATO  registered word to downstream
valido  output  1  dato_o valid
listo  input  1  downstream ready
suma  output  ANCHO_SUMA  running sum of words delivered in current run
ocupado  output  1  run in progress
fin  output  1  one-cycle pulse, run complete
error  output  1  last start request rejected (sticky)

Behaviour:
- One clock. Reset is asynchronous and active-high.
- On rst=1 (async, any state, including mid-run): state=IDLE, direccion=0, dato_o=0, valido=0, suma=0, ocupado=0, fin=0, error=0, latched end address=0.
- All outputs are registered. fin defaults to 0 every cycle unless set as below.
- States: IDLE, LEER, ENTREGAR.
- IDLE, inicio=1:
  - If dir_inicio>dir_fin or dir_fin>=PROFUNDIDAD: error<=1, stay IDLE, all other outputs unchanged.
  - Otherwise: error<=0, direccion<=dir_inicio, latch dir_fin, suma<=0, ocupado<=1, go to LEER.
- IDLE, inicio=0: hold all outputs.
- LEER (one cycle):
  - dato_o<=dato_rom
  - suma<=suma+zero-extended dato_rom, modulo 2^ANCHO_SUMA
  - valido<=1
  - go to ENTREGAR
- ENTREGAR:
  - Hold valido=1 and a stable dato_o until listo=1.
  - Handshake = valido&listo at a rising edge. On handshake, valido<=0.
  - If direccion==latched end: ocupado<=0, fin<=1, go to IDLE. direccion keeps the last address.
  - Else: direccion<=direccion+1, go to LEER.
- Timing:
  - First valido is 2 cycles after the inicio edge.
  - Maximum throughput is one word per 2 cycles (listo held high).
  - fin and ocupado=0 appear in the cycle after the last handshake.
- inicio, dir_inicio and dir_fin are ignored while ocupado=1.
- Single-word range (dir_inicio==dir_fin): exactly one word, then fin.
- direccion never exceeds the latched end, so it cannot wrap. A range check guarantees the ROM is never addressed at or beyond PROFUNDIDAD.
- listo asserted while valido=0 has no effect.
- suma is stable outside LEER and holds its final value after fin until the next accepted inicio.

Test Plan:
- Reset mid-run (assert rst while valido=1 in the run dir_inicio=2, dir_fin=7) -> all outputs 0 asynchronously, before the next edge. After release, state is IDLE and inicio restarts cleanly.
- inicio with dir_inicio=0, dir_fin=2, listo=1 constant -> dato_o sequence 90,80,70. valido high at cycles 2,4,6 after the start edge. fin pulse one cycle after the 3rd handshake. suma=240, ocupado=0.
- Full range 0..10 with listo toggling randomly (hold ≥3 cycles low at times) -> dato_o stable while valido=1 and listo=0. Sequence is 90,80,70,60,50,40,30,20,10,100,101 with no duplicates or drops. suma=651.
- Single word dir_inicio=dir_fin=9 -> one transfer of 100. fin asserted, suma=100, direccion=9.
- Rejected starts:
  - dir_inicio=5, dir_fin=3 -> error=1, ocupado stays 0, no valido.
  - dir_fin=11 -> error=1.
  - Next valid inicio (4..4) -> error clears, dato_o=50.
- inicio pulsed during a run (0..3, listo=0 stall) -> ignored. Run completes with 90,80,70,60, and latched range unchanged.

Source files
------------

// File: rtl/rom_secuenciador_if.sv
// rtl/rom_secuenciador_if.sv - control, ROM and downstream handshake bus of the ROM sequencer
interface rom_secuenciador_if #(
   parameter int ANCHO_DIR  = 8,
   parameter int ANCHO_DATO = 8,
   parameter int ANCHO_SUMA = 16
);
   logic                  inicio;
   logic [ANCHO_DIR-1:0]  dir_inicio;
   logic [ANCHO_DIR-1:0]  dir_fin;
   logic [ANCHO_DIR-1:0]  direccion;
   logic [ANCHO_DATO-1:0] dato_rom;
   logic [ANCHO_DATO-1:0] dato_o;
   logic                  valido;
   logic                  listo;
   logic [ANCHO_SUMA-1:0] suma;
   logic                  ocupado;
   logic                  fin;
   logic                  error;

   modport master (
      output inicio, dir_inicio, dir_fin, dato_rom, listo,
      input  direccion, dato_o, valido, suma, ocupado, fin, error
   );

   modport slave (
      input  inicio, dir_inicio, dir_fin, dato_rom, listo,
      output direccion, dato_o, valido, suma, ocupado, fin, error
   );
endinterface

// File: rtl/rom_secuenciador.sv
// rtl/rom_secuenciador.sv - walks an inclusive ROM address range, hands words downstream, keeps a running sum
module rom_secuenciador #(
   parameter int ANCHO_DIR   = 8,
   parameter int ANCHO_DATO  = 8,
   parameter int PROFUNDIDAD = 11,
   parameter int ANCHO_SUMA  = 16
) (
   input logic              clk,
   input logic              rst,
   rom_secuenciador_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LEER, ENTREGAR} estado_t;

   localparam logic [ANCHO_DIR-1:0] PROF_DIR = ANCHO_DIR'(PROFUNDIDAD);

   estado_t               estado, estado_d;
   logic [ANCHO_DIR-1:0]  dir_q, dir_d;
   logic [ANCHO_DIR-1:0]  fin_dir_q, fin_dir_d;
   logic [ANCHO_DATO-1:0] dato_q, dato_d;
   logic                  valido_q, valido_d;
   logic [ANCHO_SUMA-1:0] suma_q, suma_d;
   logic                  ocupado_q, ocupado_d;
   logic                  fin_q, fin_d;
   logic                  error_q, error_d;
   logic                  rechazo;
   logic                  ultimo;

   // A range is refused when reversed or when its end lies past the last ROM word
   assign rechazo = (bus.dir_inicio > bus.dir_fin) || (bus.dir_fin >= PROF_DIR);
   assign ultimo  = (dir_q == fin_dir_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado    <= IDLE;
         dir_q     <= '0;
         fin_dir_q <= '0;
         dato_q    <= '0;
         valido_q  <= 1'b0;
         suma_q    <= '0;
         ocupado_q <= 1'b0;
         fin_q     <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         estado    <= estado_d;
         dir_q     <= dir_d;
         fin_dir_q <= fin_dir_d;
         dato_q    <= dato_d;
         valido_q  <= valido_d;
         suma_q    <= suma_d;
         ocupado_q <= ocupado_d;
         fin_q     <= fin_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      estado_d = estado;
      case (estado)
         IDLE:     if (bus.inicio && !rechazo) estado_d = LEER;
         LEER:     estado_d = ENTREGAR;
         ENTREGAR: if (valido_q && bus.listo) estado_d = ultimo ? IDLE : LEER;
         default:  estado_d = IDLE;
      endcase
   end

   always_comb begin
      dir_d     = dir_q;
      fin_dir_d = fin_dir_q;
      dato_d    = dato_q;
      valido_d  = valido_q;
      suma_d    = suma_q;
      ocupado_d = ocupado_q;
      fin_d     = 1'b0;
      error_d   = error_q;
      case (estado)
         IDLE: begin
            if (bus.inicio) begin
               if (rechazo) begin
                  error_d = 1'b1;
               end else begin
                  error_d   = 1'b0;
                  dir_d     = bus.dir_inicio;
                  fin_dir_d = bus.dir_fin;
                  suma_d    = '0;
                  ocupado_d = 1'b1;
               end
            end
         end
         LEER: begin
            dato_d   = bus.dato_rom;
            suma_d   = suma_q + ANCHO_SUMA'(bus.dato_rom);
            valido_d = 1'b1;
         end
         ENTREGAR: begin
            // The last address is kept on the bus after the final handshake
            if (valido_q && bus.listo) begin
               valido_d = 1'b0;
               if (ultimo) begin
                  ocupado_d = 1'b0;
                  fin_d     = 1'b1;
               end else begin
                  dir_d = dir_q + ANCHO_DIR'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.direccion = dir_q;
   assign bus.dato_o    = dato_q;
   assign bus.valido    = valido_q;
   assign bus.suma      = suma_q;
   assign bus.ocupado   = ocupado_q;
   assign bus.fin       = fin_q;
   assign bus.error     = error_q;
endmodule

// File: tb/tb_rom_secuenciador.sv
// tb/tb_rom_secuenciador.sv - scoreboard bench for rom_secuenciador against an 11-word ROM model
module tb_rom_secuenciador;
   logic clk = 1'b0;
   logic rst = 1'b1;

   rom_secuenciador_if #(.ANCHO_DIR(8), .ANCHO_DATO(8), .ANCHO_SUMA(16)) bus ();

   rom_secuenciador #(
      .ANCHO_DIR(8), .ANCHO_DATO(8), .PROFUNDIDAD(11), .ANCHO_SUMA(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [0:10] = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40,
                              8'd30, 8'd20, 8'd10, 8'd100, 8'd101};

   always_comb begin
      if (bus.direccion < 8'd11) bus.dato_rom = rom[bus.direccion[3:0]];
      else                       bus.dato_rom = 8'h00;
   end

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   // modo 0: listo always high, 1: stall pattern, 2: listo held low
   int modo = 2;
   int ciclo = 0;
   logic [15:0] patron = 16'b1000_1101_0000_1011;

   always @(posedge clk) begin
      #1;
      ciclo = ciclo + 1;
      case (modo)
         0:       bus.listo = 1'b1;
         1:       bus.listo = patron[ciclo % 16];
         default: bus.listo = 1'b0;
      endcase
   end

   task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      checks = checks + 1;
      if (actual !== esperado) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
      end
   endtask

   logic       pendiente = 1'b0;
   logic [7:0] previo = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         pendiente = 1'b0;
      end else begin
         if (pendiente) begin
            chk("valido held during stall", 32'(bus.valido), 32'd1);
            chk("dato_o stable during stall", 32'(bus.dato_o), 32'(previo));
         end
         pendiente = bus.valido && !bus.listo;
         previo    = bus.dato_o;
         if (bus.valido && bus.listo) begin
            if (exp_q.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected word: got %0d expected none", bus.dato_o);
            end else begin
               chk("delivered word", 32'(bus.dato_o), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic empujar(input int a, input int b);
      for (int i = a; i <= b; i++) exp_q.push_back(rom[i]);
   endtask

   task automatic arrancar(input logic [7:0] a, input logic [7:0] b);
      @(posedge clk); #1;
      bus.inicio = 1'b1; bus.dir_inicio = a; bus.dir_fin = b;
      @(posedge clk); #1;
      bus.inicio = 1'b0;
   endtask

   task automatic esperar_fin(input string nombre);
      logic visto;
      visto = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (bus.fin) begin visto = 1'b1; break; end
      end
      chk({nombre, " fin pulse"}, 32'(visto), 32'd1);
      chk({nombre, " ocupado cleared"}, 32'(bus.ocupado), 32'd0);
      chk({nombre, " queue drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic esperar_valido(input string nombre);
      logic visto;
      visto = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.valido) begin visto = 1'b1; break; end
      end
      chk({nombre, " valido seen"}, 32'(visto), 32'd1);
   endtask

   initial begin
      bus.inicio = 1'b0; bus.dir_inicio = 8'd0; bus.dir_fin = 8'd0; bus.listo = 1'b0;
      #23;
      chk("reset direccion", 32'(bus.direccion), 32'd0);
      chk("reset dato_o", 32'(bus.dato_o), 32'd0);
      chk("reset valido", 32'(bus.valido), 32'd0);
      chk("reset suma", 32'(bus.suma), 32'd0);
      chk("reset ocupado", 32'(bus.ocupado), 32'd0);
      chk("reset fin", 32'(bus.fin), 32'd0);
      chk("reset error", 32'(bus.error), 32'd0);
      rst = 1'b0;

      // 0..2 with listo constant high, latency of first word
      modo = 0;
      empujar(0, 2);
      arrancar(8'd0, 8'd2);
      chk("valido low in read cycle", 32'(bus.valido), 32'd0);
      chk("ocupado after start", 32'(bus.ocupado), 32'd1);
      @(posedge clk); #1;
      chk("first valido latency", 32'(bus.valido), 32'd1);
      chk("first word", 32'(bus.dato_o), 32'd90);
      esperar_fin("run 0..2");
      chk("run 0..2 suma", 32'(bus.suma), 32'd240);
      @(posedge clk); #1;
      chk("fin is one pulse", 32'(bus.fin), 32'd0);
      chk("suma holds after fin", 32'(bus.suma), 32'd240);

      // full range with stalls
      modo = 1;
      empujar(0, 10);
      arrancar(8'd0, 8'd10);
      esperar_fin("run 0..10");
      chk("run 0..10 suma", 32'(bus.suma), 32'd651);
      chk("run 0..10 direccion", 32'(bus.direccion), 32'd10);

      // single word
      modo = 0;
      empujar(9, 9);
      arrancar(8'd9, 8'd9);
      esperar_fin("run 9..9");
      chk("run 9..9 suma", 32'(bus.suma), 32'd100);
      chk("run 9..9 direccion", 32'(bus.direccion), 32'd9);

      // rejected ranges
      arrancar(8'd5, 8'd3);
      chk("reversed range error", 32'(bus.error), 32'd1);
      chk("reversed range ocupado", 32'(bus.ocupado), 32'd0);
      @(posedge clk); #1;
      chk("reversed range no valido", 32'(bus.valido), 32'd0);
      chk("reversed range suma kept", 32'(bus.suma), 32'd100);
      arrancar(8'd0, 8'd11);
      chk("end past rom error", 32'(bus.error), 32'd1);
      chk("end past rom ocupado", 32'(bus.ocupado), 32'd0);
      empujar(4, 4);
      arrancar(8'd4, 8'd4);
      chk("error cleared", 32'(bus.error), 32'd0);
      esperar_fin("run 4..4");
      chk("run 4..4 dato_o", 32'(bus.dato_o), 32'd50);
      chk("run 4..4 suma", 32'(bus.suma), 32'd50);

      // inicio during a stalled run is ignored
      modo = 2;
      empujar(0, 3);
      arrancar(8'd0, 8'd3);
      esperar_valido("run 0..3");
      bus.inicio = 1'b1; bus.dir_inicio = 8'd5; bus.dir_fin = 8'd9;
      repeat (2) @(posedge clk);
      #1; bus.inicio = 1'b0;
      chk("ignored inicio dato_o", 32'(bus.dato_o), 32'd90);
      chk("ignored inicio ocupado", 32'(bus.ocupado), 32'd1);
      chk("ignored inicio error", 32'(bus.error), 32'd0);
      modo = 0;
      esperar_fin("run 0..3");
      chk("run 0..3 suma", 32'(bus.suma), 32'd300);
      chk("run 0..3 direccion", 32'(bus.direccion), 32'd3);

      // asynchronous reset mid-run
      modo = 2;
      empujar(2, 7);
      arrancar(8'd2, 8'd7);
      esperar_valido("run 2..7");
      #2; rst = 1'b1;
      #1;
      chk("async rst direccion", 32'(bus.direccion), 32'd0);
      chk("async rst dato_o", 32'(bus.dato_o), 32'd0);
      chk("async rst valido", 32'(bus.valido), 32'd0);
      chk("async rst suma", 32'(bus.suma), 32'd0);
      chk("async rst ocupado", 32'(bus.ocupado), 32'd0);
      exp_q.delete();
      @(posedge clk); #3; rst = 1'b0;
      @(posedge clk); #1;
      chk("after rst idle", 32'(bus.ocupado), 32'd0);
      modo = 0;
      empujar(1, 2);
      arrancar(8'd1, 8'd2);
      esperar_fin("restart 1..2");
      chk("restart suma", 32'(bus.suma), 32'd150);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
